// File: rtl/regtest_stim_pkg.sv
// Shared types, defaults and the LFSR step function for the register-test stimulus generator.
package regtest_stim_pkg;

  localparam int unsigned DATA_W          = 32;
  localparam int unsigned CNT_W           = 16;
  localparam int unsigned LED_W           = 8;
  localparam int unsigned HOLD_CYCLES_DEF = 3;
  localparam logic [DATA_W-1:0] LFSR_TAPS_DEF = 32'h8020_0003;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // One Galois shift: shift right, xor the tap mask in when the bit leaving the register was set.
  function automatic logic [DATA_W-1:0] lfsr_step(input logic [DATA_W-1:0] v,
                                                 input logic [DATA_W-1:0] taps);
    return (v >> 1) ^ (v[0] ? taps : {DATA_W{1'b0}});
  endfunction

endpackage

// File: rtl/regtest_stim_if.sv
// Stimulus/result signals between the run controller and whoever drives it.
interface regtest_stim_if;
  import regtest_stim_pkg::*;

  logic                start;
  logic [DATA_W-1:0]   seed;
  logic [CNT_W-1:0]    rounds;
  logic [LED_W-1:0]    led_in;
  logic [DATA_W-1:0]   instr;
  logic                busy;
  logic                done;
  logic [DATA_W-1:0]   signature;
  logic [CNT_W-1:0]    round_cnt;

  modport master (
    output start, seed, rounds, led_in,
    input  instr, busy, done, signature, round_cnt
  );

  modport slave (
    input  start, seed, rounds, led_in,
    output instr, busy, done, signature, round_cnt
  );

endinterface

// File: rtl/regtest_lfsr32.sv
// 32-bit Galois LFSR with synchronous load and step enable; load wins over step.
module regtest_lfsr32
  import regtest_stim_pkg::*;
#(
  parameter logic [DATA_W-1:0] TAPS = LFSR_TAPS_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              load,
  input  logic              step,
  input  logic [DATA_W-1:0] seed,
  output logic [DATA_W-1:0] q
);

  // LFSR register; the caller never loads zero, so the lock-up state is unreachable.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      q <= DATA_W'(1);
    end else if (load) begin
      q <= seed;
    end else if (step) begin
      q <= lfsr_step(q, TAPS);
    end
  end

endmodule

// File: rtl/regtest_stim.sv
// Run controller: issues LFSR instruction words, each held for HOLD_CYCLES, and folds the core's results.
module regtest_stim
  import regtest_stim_pkg::*;
#(
  parameter int unsigned       HOLD_CYCLES = HOLD_CYCLES_DEF,  // at least 2
  parameter logic [DATA_W-1:0] LFSR_TAPS   = LFSR_TAPS_DEF
) (
  input  logic           clk,
  input  logic           rstn,
  regtest_stim_if.slave  bus
);

  localparam int unsigned    HC_W    = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HC_W-1:0] HC_LAST = HC_W'(HOLD_CYCLES - 1);

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  instr_q, instr_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [DATA_W-1:0]  sig_q, sig_d;
  logic [CNT_W-1:0]   rc_q, rc_d;
  logic [CNT_W-1:0]   rounds_q, rounds_d;
  logic [HC_W-1:0]    hold_q, hold_d;

  logic               lfsr_load;
  logic               lfsr_adv;
  logic [DATA_W-1:0]  lfsr_q;
  logic [DATA_W-1:0]  seed_eff;
  logic [DATA_W-1:0]  fold;
  logic [CNT_W-1:0]   rc_inc;

  // A zero seed would lock the LFSR, so it is remapped to 1.
  assign seed_eff = (bus.seed == '0) ? DATA_W'(1) : bus.seed;

  // Rotate-left-by-one of the signature, xor'd with the result byte of the word just finished.
  assign fold   = {sig_q[DATA_W-2:0], sig_q[DATA_W-1]} ^ {{(DATA_W-LED_W){1'b0}}, bus.led_in};
  assign rc_inc = rc_q + CNT_W'(1);

  regtest_lfsr32 #(
    .TAPS (LFSR_TAPS)
  ) u_lfsr (
    .clk  (clk),
    .rstn (rstn),
    .load (lfsr_load),
    .step (lfsr_adv),
    .seed (seed_eff),
    .q    (lfsr_q)
  );

  // Next-state and next-register values; busy/done are decoded from the next state so they stay registered.
  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    sig_d     = sig_q;
    rc_d      = rc_q;
    rounds_d  = rounds_q;
    hold_d    = hold_q;
    lfsr_load = 1'b0;
    lfsr_adv  = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          sig_d = '0;
          rc_d  = '0;
          if (bus.rounds != '0) begin
            rounds_d  = bus.rounds;
            lfsr_load = 1'b1;
            instr_d   = seed_eff;
            hold_d    = '0;
            state_d   = ST_RUN;
          end else begin
            state_d   = ST_DONE;
          end
        end
      end

      ST_RUN: begin
        // The first cycle of every word after the first folds the previous word's result.
        if (hold_q == '0 && rc_q != '0) begin
          sig_d = fold;
        end
        if (hold_q == HC_LAST) begin
          hold_d = '0;
          rc_d   = rc_inc;
          if (rc_inc == rounds_q) begin
            state_d = ST_DRAIN;
          end else begin
            lfsr_adv = 1'b1;
            instr_d  = lfsr_step(lfsr_q, LFSR_TAPS);
          end
        end else begin
          hold_d = hold_q + HC_W'(1);
        end
      end

      ST_DRAIN: begin
        sig_d   = fold;
        state_d = ST_DONE;
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    done_d = (state_d == ST_DONE);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      instr_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sig_q    <= '0;
      rc_q     <= '0;
      rounds_q <= '0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      sig_q    <= sig_d;
      rc_q     <= rc_d;
      rounds_q <= rounds_d;
      hold_q   <= hold_d;
    end
  end

  assign bus.instr     = instr_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.signature = sig_q;
  assign bus.round_cnt = rc_q;

endmodule

// File: tb/tb_regtest_stim.sv
// Directed bench for regtest_stim with a queue scoreboard and a small stand-in for the register-file core.
module tb_regtest_stim;

  logic clk = 1'b0;
  logic rstn;
  int   total  = 0;
  int   passed = 0;

  bit        core_en   = 1'b0;
  logic [7:0] led_const = 8'h00;

  logic [31:0] exp_instr_q[$];
  logic [31:0] exp_sig_q[$];
  logic [15:0] exp_rc_q[$];
  int          exp_lat_q[$];

  regtest_stim_if bus ();

  regtest_stim #(
    .HOLD_CYCLES (3),
    .LFSR_TAPS   (32'h8020_0003)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Stand-in core: registers a byte derived from the current instruction, or a fixed byte.
  always @(posedge clk) begin
    if (!rstn) bus.led_in <= 8'h00;
    else       bus.led_in <= core_en ? (bus.instr[7:0] ^ bus.instr[31:24]) : led_const;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] tb_step(input logic [31:0] v);
    logic [31:0] sh;
    sh = {1'b0, v[31:1]};
    if (v[0]) sh = sh ^ 32'h8020_0003;
    return sh;
  endfunction

  function automatic logic [31:0] model_sig(input logic [31:0] s, input int n,
                                            input bit core, input logic [7:0] c);
    logic [31:0] w;
    logic [31:0] acc;
    logic [7:0]  res;
    w   = (s == 32'h0) ? 32'h1 : s;
    acc = 32'h0;
    for (int k = 0; k < n; k++) begin
      res = core ? (w[7:0] ^ w[31:24]) : c;
      acc = {acc[30:0], acc[31]} ^ {24'h0, res};
      w   = tb_step(w);
    end
    return acc;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ":instr0"}, bus.instr, 32'h0);
    chk({tag, ":busy0"}, 32'(bus.busy), 32'h0);
    chk({tag, ":done0"}, 32'(bus.done), 32'h0);
    chk({tag, ":sig0"}, bus.signature, 32'h0);
    chk({tag, ":rc0"}, 32'(bus.round_cnt), 32'h0);
  endtask

  // One run: push expectations, pulse start, follow the run to done (or abort by reset), then compare.
  task automatic do_run(input string tag, input logic [31:0] s, input logic [15:0] r,
                        input int glitch_at, input int abort_at);
    logic [31:0] w;
    logic [31:0] e_sig;
    logic [15:0] e_rc;
    int          e_lat;
    int          lat;
    bit          saw_busy;
    bit          aborted;

    w = (s == 32'h0) ? 32'h1 : s;
    for (int k = 0; k < int'(r); k++) begin
      for (int h = 0; h < 3; h++) exp_instr_q.push_back(w);
      if (k == int'(r) - 1) exp_instr_q.push_back(w);
      else w = tb_step(w);
    end
    exp_sig_q.push_back(model_sig(s, int'(r), core_en, led_const));
    exp_rc_q.push_back(r);
    exp_lat_q.push_back((r == 16'h0) ? 0 : int'(r) * 3 + 1);

    bus.seed   = s;
    bus.rounds = r;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
    lat      = 0;
    saw_busy = 1'b0;
    aborted  = 1'b0;

    while (!bus.done && lat < 1000) begin
      if (bus.busy) begin
        saw_busy = 1'b1;
        if (exp_instr_q.size() != 0) chk({tag, ":instr"}, bus.instr, exp_instr_q.pop_front());
        else chk({tag, ":busy_overrun"}, 32'(lat), 32'hFFFF_FFFF);
      end
      if (lat == glitch_at) begin
        bus.seed   = ~s;
        bus.rounds = 16'd5;
        bus.start  = 1'b1;
      end
      if (lat == abort_at) begin
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        aborted = 1'b1;
        break;
      end
      @(negedge clk);
      bus.start = 1'b0;
      lat++;
    end

    if (aborted) begin
      chk_zero({tag, ":abort"});
      exp_instr_q.delete();
      exp_sig_q.delete();
      exp_rc_q.delete();
      exp_lat_q.delete();
      return;
    end

    e_sig = exp_sig_q.pop_front();
    e_rc  = exp_rc_q.pop_front();
    e_lat = exp_lat_q.pop_front();
    chk({tag, ":latency"}, 32'(lat), 32'(e_lat));
    chk({tag, ":sig"}, bus.signature, e_sig);
    chk({tag, ":rc"}, 32'(bus.round_cnt), 32'(e_rc));
    chk({tag, ":done"}, 32'(bus.done), 32'h1);
    chk({tag, ":busy"}, 32'(bus.busy), 32'h0);
    chk({tag, ":instr_left"}, 32'(exp_instr_q.size()), 32'h0);
    if (r == 16'h0) chk({tag, ":busy_seen"}, 32'(saw_busy), 32'h0);
    exp_instr_q.delete();

    idle(2);
    chk({tag, ":sig_hold"}, bus.signature, e_sig);
    chk({tag, ":done_hold"}, 32'(bus.done), 32'h1);
  endtask

  initial begin
    rstn       = 1'b0;
    bus.start  = 1'b0;
    bus.seed   = 32'h0;
    bus.rounds = 16'h0;
    idle(3);
    chk_zero("reset");
    rstn = 1'b1;
    idle(1);

    // single word, fixed result byte
    led_const = 8'hA5;
    idle(2);
    do_run("one_word", 32'h1234_5678, 16'd1, -1, -1);

    // zero seed remapped, two words, restarted from DONE
    led_const = 8'h01;
    idle(2);
    do_run("zero_seed", 32'h0, 16'd2, -1, -1);

    // zero rounds goes straight to DONE
    do_run("zero_rounds", 32'hFFFF_0000, 16'd0, -1, -1);

    // start while busy must be ignored
    led_const = 8'h3C;
    idle(2);
    do_run("busy_start", 32'hCAFE_F00D, 16'd2, 1, -1);

    // reset during the second word, then a clean run
    led_const = 8'h5A;
    idle(2);
    do_run("abort", 32'h0BAD_CAFE, 16'd3, -1, 4);
    do_run("after_abort", 32'h1, 16'd1, -1, -1);

    // 16 rounds against the stand-in core
    core_en = 1'b1;
    idle(2);
    do_run("core16", 32'hDEAD_BEEF, 16'd16, -1, -1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
